tournament_predictor_param: RTL and testbench

Parametrised two-component tournament branch predictor (gshare + bimodal) with a per-PC chooser table and a speculative global history register (GHR).
- Lookup is registered: the fetch-stage request returns its prediction one cycle later.
- Resolution updates all tables and repairs the GHR on a mispredict.
- A mode input forces a single provider for debug and performance characterisation.

---
 rtl/tournament_predictor_param.sv | 138 +++++++++++++
 tb/tb_tournament_predictor_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_predictor_param.sv
// Tournament branch predictor: gshare + bimodal components, per-PC chooser,
// speculative global history with repair on mispredict. Lookup is registered.
module tournament_predictor_param #(
    parameter int PC_BITS      = 16,
    parameter int INDEX_BITS   = 8,
    parameter int HISTORY_LEN  = 8,
    parameter int CTR_BITS     = 2,
    parameter int CHOOSER_BITS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lookup_en,
    input  logic [PC_BITS-1:0]     pc_lookup,
    output logic                   pred_valid,
    output logic                   prediction,
    output logic                   gshare_pred,
    output logic                   bimodal_pred,
    output logic                   provider,
    output logic [HISTORY_LEN-1:0] history_snapshot,
    input  logic                   update_en,
    input  logic [PC_BITS-1:0]     pc_update,
    input  logic [HISTORY_LEN-1:0] history_update,
    input  logic                   outcome,
    input  logic                   gshare_pred_update,
    input  logic                   bimodal_pred_update,
    input  logic                   mispredict,
    input  logic [1:0]             force_mode
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]     CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0]     CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [CHOOSER_BITS-1:0] CHO_INIT = {1'b0, {(CHOOSER_BITS-1){1'b1}}};
    localparam logic [CHOOSER_BITS-1:0] CHO_ONE  = {{(CHOOSER_BITS-1){1'b0}}, 1'b1};

    logic [CTR_BITS-1:0]     bim_tbl [ENTRIES];
    logic [CTR_BITS-1:0]     gsh_tbl [ENTRIES];
    logic [CHOOSER_BITS-1:0] cho_tbl [ENTRIES];
    logic [HISTORY_LEN-1:0]  ghr;

    logic [INDEX_BITS-1:0]   ghr_ext, hist_ext;
    logic [INDEX_BITS-1:0]   lk_idx, lk_gidx, up_idx, up_gidx;
    logic                    lk_bim, lk_gsh, lk_cho, lk_prov, lk_pred;
    logic [CTR_BITS-1:0]     bim_nxt, gsh_nxt;
    logic [CHOOSER_BITS-1:0] cho_nxt;
    logic                    cho_we;
    logic                    unused_pc_bits;

    assign unused_pc_bits = ^{pc_lookup[PC_BITS-1:INDEX_BITS], pc_update[PC_BITS-1:INDEX_BITS]};

    function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
        if (up) return (c == '1) ? c : c + CTR_ONE;
        else    return (c == '0) ? c : c - CTR_ONE;
    endfunction

    function automatic logic [CHOOSER_BITS-1:0] cho_step(input logic [CHOOSER_BITS-1:0] c, input logic up);
        if (up) return (c == '1) ? c : c + CHO_ONE;
        else    return (c == '0) ? c : c - CHO_ONE;
    endfunction

    always_comb begin
        ghr_ext                    = '0;
        ghr_ext[HISTORY_LEN-1:0]   = ghr;
        hist_ext                   = '0;
        hist_ext[HISTORY_LEN-1:0]  = history_update;

        lk_idx  = pc_lookup[INDEX_BITS-1:0];
        lk_gidx = lk_idx ^ ghr_ext;
        lk_bim  = bim_tbl[lk_idx][CTR_BITS-1];
        lk_gsh  = gsh_tbl[lk_gidx][CTR_BITS-1];
        lk_cho  = cho_tbl[lk_idx][CHOOSER_BITS-1];

        lk_prov = lk_cho;
        lk_pred = lk_cho ? lk_gsh : lk_bim;
        case (force_mode)
            2'b01:   begin lk_prov = 1'b1; lk_pred = lk_gsh; end
            2'b10:   begin lk_prov = 1'b0; lk_pred = lk_bim; end
            2'b11:   begin lk_prov = 1'b0; lk_pred = 1'b1;   end
            default: ;
        endcase

        up_idx  = pc_update[INDEX_BITS-1:0];
        up_gidx = up_idx ^ hist_ext;
        bim_nxt = ctr_step(bim_tbl[up_idx], outcome);
        gsh_nxt = ctr_step(gsh_tbl[up_gidx], outcome);
        cho_we  = update_en && (gshare_pred_update != bimodal_pred_update);
        cho_nxt = cho_step(cho_tbl[up_idx], gshare_pred_update == outcome);
    end

    // Table reads above use pre-edge contents, so a same-index lookup never sees this update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                bim_tbl[INDEX_BITS'(i)] <= CTR_INIT;
                gsh_tbl[INDEX_BITS'(i)] <= CTR_INIT;
                cho_tbl[INDEX_BITS'(i)] <= CHO_INIT;
            end
        end else begin
            if (update_en) begin
                bim_tbl[up_idx]  <= bim_nxt;
                gsh_tbl[up_gidx] <= gsh_nxt;
            end
            if (cho_we) cho_tbl[up_idx] <= cho_nxt;
        end
    end

    // Repair wins over the speculative shift of a same-cycle lookup.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else if (update_en && mispredict) begin
            ghr <= {history_update[HISTORY_LEN-2:0], outcome};
        end else if (lookup_en) begin
            ghr <= {ghr[HISTORY_LEN-2:0], lk_pred};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_valid       <= 1'b0;
            prediction       <= 1'b0;
            gshare_pred      <= 1'b0;
            bimodal_pred     <= 1'b0;
            provider         <= 1'b0;
            history_snapshot <= '0;
        end else begin
            pred_valid <= lookup_en;
            if (lookup_en) begin
                prediction       <= lk_pred;
                gshare_pred      <= lk_gsh;
                bimodal_pred     <= lk_bim;
                provider         <= lk_prov;
                history_snapshot <= ghr;
            end
        end
    end

endmodule

// File: tb/tb_tournament_predictor_param.sv
// Self-checking bench for tournament_predictor_param: directed steps followed by
// randomized lookup/resolve traffic against an arithmetic reference model.
module tb_tournament_predictor_param;

    localparam int PCB   = 16;
    localparam int IB    = 8;
    localparam int HL    = 8;
    localparam int CB    = 2;
    localparam int HB    = 2;
    localparam int N     = 1 << IB;
    localparam int CMAX  = (1 << CB) - 1;
    localparam int CHALF = 1 << (CB - 1);
    localparam int HMAX  = (1 << HB) - 1;
    localparam int HHALF = 1 << (HB - 1);
    localparam int GMASK = (1 << HL) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          lookup_en;
    logic [PCB-1:0] pc_lookup;
    logic          pred_valid, prediction, gshare_pred, bimodal_pred, provider;
    logic [HL-1:0] history_snapshot;
    logic          update_en;
    logic [PCB-1:0] pc_update;
    logic [HL-1:0] history_update;
    logic          outcome, gshare_pred_update, bimodal_pred_update, mispredict;
    logic [1:0]    force_mode;

    tournament_predictor_param #(
        .PC_BITS(PCB), .INDEX_BITS(IB), .HISTORY_LEN(HL),
        .CTR_BITS(CB), .CHOOSER_BITS(HB)
    ) dut (
        .clk(clk), .reset(reset), .lookup_en(lookup_en), .pc_lookup(pc_lookup),
        .pred_valid(pred_valid), .prediction(prediction), .gshare_pred(gshare_pred),
        .bimodal_pred(bimodal_pred), .provider(provider), .history_snapshot(history_snapshot),
        .update_en(update_en), .pc_update(pc_update), .history_update(history_update),
        .outcome(outcome), .gshare_pred_update(gshare_pred_update),
        .bimodal_pred_update(bimodal_pred_update), .mispredict(mispredict),
        .force_mode(force_mode)
    );

    always #5 clk = ~clk;

    // Reference model: counters as plain integers, history as an integer.
    int bim_m [N];
    int gsh_m [N];
    int cho_m [N];
    int ghr_m;
    int tests = 0;
    int fails = 0;
    int e_pred, e_gp, e_bp, e_prov, e_snap;

    typedef struct {
        int pc;
        int snap;
        int gp;
        int bp;
        int pred;
    } inflight_t;
    inflight_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            bim_m[i] = CHALF - 1;
            gsh_m[i] = CHALF - 1;
            cho_m[i] = HHALF - 1;
        end
        ghr_m = 0;
    endtask

    function automatic int clamp(input int v, input int mx);
        return (v < 0) ? 0 : ((v > mx) ? mx : v);
    endfunction

    task automatic step(input bit le, input int pc, input bit ue, input int pcu, input int hu,
                        input bit outc, input bit gpu, input bit bpu, input bit misp, input int fm);
        int idx, gi, ui, d;
        bit ch;
        lookup_en = le;  pc_lookup = PCB'(pc);  force_mode = 2'(fm);
        update_en = ue;  pc_update = PCB'(pcu); history_update = HL'(hu);
        outcome = outc;  gshare_pred_update = gpu; bimodal_pred_update = bpu; mispredict = misp;

        idx    = pc % N;
        gi     = idx ^ ghr_m;
        e_bp   = (bim_m[idx] >= CHALF) ? 1 : 0;
        e_gp   = (gsh_m[gi] >= CHALF) ? 1 : 0;
        ch     = (cho_m[idx] >= HHALF);
        e_snap = ghr_m;
        case (fm)
            1:       begin e_prov = 1; e_pred = e_gp; end
            2:       begin e_prov = 0; e_pred = e_bp; end
            3:       begin e_prov = 0; e_pred = 1;    end
            default: begin e_prov = ch ? 1 : 0; e_pred = ch ? e_gp : e_bp; end
        endcase

        @(posedge clk);
        #1;
        if (ue) begin
            ui = pcu % N;
            d  = outc ? 1 : -1;
            bim_m[ui]      = clamp(bim_m[ui] + d, CMAX);
            gsh_m[ui ^ hu] = clamp(gsh_m[ui ^ hu] + d, CMAX);
            if (gpu != bpu) cho_m[ui] = clamp(cho_m[ui] + ((gpu == outc) ? 1 : -1), HMAX);
        end
        if (ue && misp)  ghr_m = ((hu * 2) + (outc ? 1 : 0)) & GMASK;
        else if (le)     ghr_m = ((ghr_m * 2) + e_pred) & GMASK;

        lookup_en = 1'b0; update_en = 1'b0; mispredict = 1'b0;
        check("pred_valid", 32'(pred_valid), 32'(le));
        if (le) begin
            check("prediction", 32'(prediction), 32'(e_pred));
            check("gshare_pred", 32'(gshare_pred), 32'(e_gp));
            check("bimodal_pred", 32'(bimodal_pred), 32'(e_bp));
            check("provider", 32'(provider), 32'(e_prov));
            check("history_snapshot", 32'(history_snapshot), 32'(e_snap));
        end
    endtask

    initial begin
        reset = 1'b0; lookup_en = 1'b0; pc_lookup = '0; update_en = 1'b0; pc_update = '0;
        history_update = '0; outcome = 1'b0; gshare_pred_update = 1'b0;
        bimodal_pred_update = 1'b0; mispredict = 1'b0; force_mode = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(pred_valid), 32'd0);
        check("rst_pred", 32'(prediction), 32'd0);
        check("rst_snap", 32'(history_snapshot), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: cold lookup
        step(1, 'h0010, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_pred", 32'(prediction), 32'd0);
        check("t1_prov", 32'(provider), 32'd0);
        check("t1_bp", 32'(bimodal_pred), 32'd0);

        // 2: train taken, then saturation
        repeat (3) step(0, 0, 1, 'h0010, 0, 1, 0, 0, 0, 0);
        step(1, 'h0010, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t2_bp", 32'(bimodal_pred), 32'd1);
        check("t2_gp", 32'(gshare_pred), 32'd1);
        check("t2_pred", 32'(prediction), 32'd1);
        repeat (5) step(0, 0, 1, 'h0010, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 'h0010, 0, 0, 0, 0, 0, 0);
        step(1, 'h0010, 0, 0, 0, 0, 0, 0, 0, 2);
        check("t2_sat_bp", 32'(bimodal_pred), 32'd1);

        // 3: speculative history, then repair racing a lookup
        step(0, 0, 1, 'h00FF, 0, 0, 0, 0, 1, 0);
        repeat (4) step(1, 'h0044, 0, 0, 0, 0, 0, 0, 0, 3);
        step(1, 'h0044, 1, 'h0030, 'h01, 0, 0, 0, 1, 3);
        check("t3_snap", 32'(history_snapshot), 32'h0F);
        step(1, 'h0044, 0, 0, 0, 0, 0, 0, 0, 3);
        check("t3_repair", 32'(history_snapshot), 32'h02);

        // 4: chooser training
        step(0, 0, 1, 'h0020, 0, 1, 1, 0, 0, 0);
        step(1, 'h0020, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_prov", 32'(provider), 32'd1);
        step(0, 0, 1, 'h0020, 0, 0, 1, 1, 0, 0);
        step(1, 'h0020, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_prov_hold", 32'(provider), 32'd1);

        // 5: forced modes
        step(1, 'h0055, 0, 0, 0, 0, 0, 0, 0, 3);
        check("t5_static", 32'(prediction), 32'd1);
        check("t5_static_prov", 32'(provider), 32'd0);
        step(1, 'h0020, 0, 0, 0, 0, 0, 0, 0, 2);
        check("t5_fbim_prov", 32'(provider), 32'd0);
        check("t5_fbim_pred", 32'(prediction), 32'(bimodal_pred));

        // 6: reset while a prediction is pending
        step(1, 'h0010, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check("t6_valid", 32'(pred_valid), 32'd0);
        check("t6_pred", 32'(prediction), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 'h0010, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_relookup", 32'(prediction), 32'd0);
        check("t6_bp", 32'(bimodal_pred), 32'd0);

        // Randomized traffic: resolve earlier lookups out of a FIFO.
        for (int n = 0; n < 3000; n++) begin
            bit le, ue, outc, misp;
            int pc, fm;
            inflight_t it;
            le   = ($urandom_range(0, 1) == 1);
            pc   = int'($urandom & 32'hF03F);
            ue   = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            fm   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            it   = '{0, 0, 0, 0, 0};
            outc = 1'b0;
            misp = 1'b0;
            if (ue) begin
                it   = q.pop_front();
                outc = ($urandom_range(0, 3) != 0);
                misp = (int'(outc) != it.pred);
            end
            step(le, pc, ue, it.pc, it.snap, outc, it.gp[0], it.bp[0], misp, fm);
            if (le) q.push_back('{pc, e_snap, e_gp, e_bp, e_pred});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
